water_level_decoder: RTL and testbench
======================================

// Module: water_level_decoder
// PURPOSE
//   Read-side counterpart of the water-level display driver. Samples the 14-bit
//   lines bus (7 rows x 2 bits, row 0 = lines[1:0] = bottom) and debounces it.
//   Decodes the thermometer-style fill into a 0..7 level with direction and
//   full/empty flags. Flags malformed patterns as a fault. Feeds the 7-seg/status logic.
// PARAMETERS
//   NROWS          7   rows on the bus; bus width = 2*NROWS
//   STABLE_CYCLES  4   consecutive unchanged samples required before commit (>=1)
//   CNT_W          3   stability counter width; must hold STABLE_CYCLES
// PORTS
//   clk           in   1    system clock, rising edge
//   rst           in   1    asynchronous, active-high reset
//   lines         in   14   row fields; 2'b00 empty, 2'b11 full, 2'b01/2'b10 partial
//   level         out  3    committed count of full rows (0..7)
//   level_valid   out  1    1 once any valid pattern has been committed
//   level_change  out  1    1-cycle pulse when a committed level differs from the previous one
//   moving_up     out  1    1-cycle pulse with level_change, new level > old
//   moving_down   out  1    1-cycle pulse with level_change, new level < old
//   full          out  1    committed level == NROWS
//   empty         out  1    committed level == 0 and level_valid
//   fault         out  1    malformed pattern committed; sticky until a valid commit
// BEHAVIOUR
//   Reset (async, immediate): level=0, level_valid=0, all pulses=0, full=0, empty=0,
//     fault=0, sample reg=0, counter=0, state=INIT.
//   Sampling: lines_q <= lines every edge. cnt <= 0 if lines_q != lines_q_prev, else
//     cnt+1 saturating at STABLE_CYCLES.
//   Commit: on the edge where cnt becomes STABLE_CYCLES. That is the (STABLE_CYCLES+1)th
//     rising edge at which the new value is on lines. No re-commit while saturated.
//   Decode of lines_q (combinational):
//     valid iff rows 0..k-1 == 2'b11, at most row k partial, all rows above k == 2'b00.
//     decoded level = k (number of full rows); a partial row does not count.
//   FSM states: INIT, TRACK, FAULT.
//     INIT  --valid commit-->   TRACK  level=k, level_valid=1, no change pulse.
//     INIT  --invalid commit--> FAULT  fault=1, level held at 0.
//     TRACK --valid commit-->   TRACK  if k!=level: update level, pulse level_change plus
//                                      moving_up or moving_down for exactly 1 cycle.
//     TRACK --invalid commit--> FAULT  fault=1, level and level_valid held.
//     FAULT --valid commit-->   TRACK  fault=0, level=k; pulse only if level_valid was 1
//                                      and k differs.
//     FAULT --invalid commit--> FAULT  no change.
//   full/empty are registered alongside level, so they update on the same edge.
//   Pulses are never asserted in consecutive cycles: commits need >=STABLE_CYCLES+1 edges.
//   Glitch shorter than STABLE_CYCLES+1 edges resets cnt; the committed outputs are untouched.
//   A bus change on the commit edge itself: the commit uses the old lines_q and cnt
//     restarts on the next edge.
//   rst asserted mid-operation clears everything at once, even within a debounce window.
//     Decoding restarts from INIT.
// TESTING
//   1. Reset, lines=14'h0000 held 5 edges -> level_valid=1, level=0, empty=1, no pulse.
//   2. From level 0, lines=14'h000F held -> on the 5th edge level=2, level_change=1,
//      moving_up=1 for 1 cycle. full=0, empty=0.
//   3. Level 2, lines=14'h0007 (row0 full, row1 partial) held -> level=1,
//      moving_down pulse.
//   4. lines=14'h3FFF held -> level=7, full=1. Then a 3-cycle glitch to 14'h0000,
//      back to 14'h3FFF -> no commit, no pulse, level stays 7.
//   5. lines=14'h0C03 (gap at row 1) held -> fault=1 and level holds. Then 14'h003F held
//      -> fault=0, level=3, pulse.
//   6. Assert rst mid-window (cnt=2, new pattern 14'h00FF) -> all outputs 0 at once.
//      After release, 14'h00FF held 5 edges -> level=4, level_valid=1, no pulse.

Source files
------------

// File: rtl/water_level_decoder_if.sv
// Water-level bus: sampled row lines in, decoded level and status out.
// The master side drives the lines; the decoder is the slave.
interface water_level_decoder_if #(
    parameter int NROWS = 7,
    parameter int LVL_W = $clog2(NROWS + 1)
);
    logic [2*NROWS-1:0] lines;
    logic [LVL_W-1:0]   level;
    logic               level_valid;
    logic               level_change;
    logic               moving_up;
    logic               moving_down;
    logic               full;
    logic               empty;
    logic               fault;

    modport master (
        output lines,
        input  level, level_valid, level_change,
        input  moving_up, moving_down, full, empty, fault
    );

    modport slave (
        input  lines,
        output level, level_valid, level_change,
        output moving_up, moving_down, full, empty, fault
    );
endinterface

// File: rtl/water_level_decoder.sv
// Debounces the 2-bit-per-row water-level bus and decodes the
// thermometer fill into a level with direction and fault flags.
module water_level_decoder #(
    parameter int NROWS         = 7,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    water_level_decoder_if.slave  bus
);
    localparam int LVL_W = $clog2(NROWS + 1);

    typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

    state_t             r_state, w_state_n;
    logic [2*NROWS-1:0] r_lines_q;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [LVL_W-1:0]   r_level, w_level_n;
    logic               r_valid, w_valid_n;
    logic               r_chg, w_chg_n;
    logic               r_up, w_up_n;
    logic               r_dn, w_dn_n;
    logic               r_full, w_full_n;
    logic               r_empty, w_empty_n;
    logic               r_fault, w_fault_n;

    logic [LVL_W-1:0]   w_k;
    logic               w_ok;
    logic               w_seen;
    logic               w_commit;
    logic [1:0]         w_row;

    // Thermometer decode: count full rows from the bottom; after the first
    // non-full row (which may be partial or empty) every row must be empty.
    always_comb begin
        w_k    = '0;
        w_ok   = 1'b1;
        w_seen = 1'b0;
        w_row  = 2'b00;
        for (int r = 0; r < NROWS; r++) begin
            w_row = r_lines_q[2*r +: 2];
            if (!w_seen) begin
                if (w_row == 2'b11) w_k = w_k + LVL_W'(1);
                else                w_seen = 1'b1;
            end else if (w_row != 2'b00) begin
                w_ok = 1'b0;
            end
        end
    end

    // Stability counter: a new value on the bus restarts the window.
    always_comb begin
        if (bus.lines != r_lines_q)
            w_cnt_n = '0;
        else if (r_cnt == CNT_W'(STABLE_CYCLES))
            w_cnt_n = r_cnt;
        else
            w_cnt_n = r_cnt + CNT_W'(1);
    end

    // The commit edge is the one on which the counter reaches saturation.
    assign w_commit = (r_cnt == CNT_W'(STABLE_CYCLES - 1));

    // Next-state and output decode; pulses default low every cycle.
    always_comb begin
        w_state_n = r_state;
        w_level_n = r_level;
        w_valid_n = r_valid;
        w_fault_n = r_fault;
        w_chg_n   = 1'b0;
        w_up_n    = 1'b0;
        w_dn_n    = 1'b0;
        if (w_commit) begin
            unique case (r_state)
                ST_INIT: begin
                    if (w_ok) begin
                        w_state_n = ST_TRACK;
                        w_level_n = w_k;
                        w_valid_n = 1'b1;
                    end else begin
                        w_state_n = ST_FAULT;
                        w_fault_n = 1'b1;
                    end
                end
                ST_TRACK, ST_FAULT: begin
                    if (w_ok) begin
                        w_state_n = ST_TRACK;
                        w_fault_n = 1'b0;
                        w_valid_n = 1'b1;
                        w_level_n = w_k;
                        if (r_valid && (w_k != r_level)) begin
                            w_chg_n = 1'b1;
                            w_up_n  = (w_k > r_level);
                            w_dn_n  = (w_k < r_level);
                        end
                    end else begin
                        w_state_n = ST_FAULT;
                        w_fault_n = 1'b1;
                    end
                end
                default: w_state_n = ST_INIT;
            endcase
        end
        w_full_n  = (w_level_n == LVL_W'(NROWS));
        w_empty_n = w_valid_n && (w_level_n == '0);
    end

    // State, sample and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_lines_q <= '0;
            r_cnt     <= '0;
            r_level   <= '0;
            r_valid   <= 1'b0;
            r_chg     <= 1'b0;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_full    <= 1'b0;
            r_empty   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_lines_q <= bus.lines;
            r_cnt     <= w_cnt_n;
            r_level   <= w_level_n;
            r_valid   <= w_valid_n;
            r_chg     <= w_chg_n;
            r_up      <= w_up_n;
            r_dn      <= w_dn_n;
            r_full    <= w_full_n;
            r_empty   <= w_empty_n;
            r_fault   <= w_fault_n;
        end
    end

    assign bus.level        = r_level;
    assign bus.level_valid  = r_valid;
    assign bus.level_change = r_chg;
    assign bus.moving_up    = r_up;
    assign bus.moving_down  = r_dn;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_water_level_decoder.sv
// Directed scoreboard bench for the water-level decoder.
// Expectations are queued at each stimulus step and popped at sample time.
module tb_water_level_decoder;
    logic clk;
    logic rst;

    water_level_decoder_if bus_if ();

    water_level_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] level;
        logic       valid;
        logic       chg;
        logic       up;
        logic       dn;
        logic       full;
        logic       empty;
        logic       fault;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic obs_t sample_dut();
        obs_t o;
        o.level = bus_if.level;
        o.valid = bus_if.level_valid;
        o.chg   = bus_if.level_change;
        o.up    = bus_if.moving_up;
        o.dn    = bus_if.moving_down;
        o.full  = bus_if.full;
        o.empty = bus_if.empty;
        o.fault = bus_if.fault;
        return o;
    endfunction

    // Field order: level valid chg up dn full empty fault.
    task automatic push(input string tag, input logic [2:0] lvl,
                        input logic v, input logic c, input logic u,
                        input logic d, input logic f, input logic e,
                        input logic flt);
        obs_t x;
        x = '{lvl, v, c, u, d, f, e, flt};
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        obs_t  got;
        obs_t  want;
        string tag;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty got=none exp=entry");
            return;
        end
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got  = sample_dut();
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b (lvl,v,chg,up,dn,full,empty,fault)",
                   tag, got, want);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.lines = 14'h0000;

        // Reset state.
        @(negedge clk);
        push("reset", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        check();

        // 1: empty bus, sample register already matches after reset.
        rst = 1'b0;
        edges(3);
        push("t1_precommit", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        check();
        edges(1);
        push("t1_commit", 3'd0, 1, 0, 0, 0, 0, 1, 0);
        check();
        edges(1);
        push("t1_hold", 3'd0, 1, 0, 0, 0, 0, 1, 0);
        check();

        // 2: two full rows, commit on the 5th edge.
        bus_if.lines = 14'h000F;
        edges(4);
        push("t2_edge4", 3'd0, 1, 0, 0, 0, 0, 1, 0);
        check();
        edges(1);
        push("t2_edge5", 3'd2, 1, 1, 1, 0, 0, 0, 0);
        check();
        edges(1);
        push("t2_pulse_end", 3'd2, 1, 0, 0, 0, 0, 0, 0);
        check();

        // 3: one full row plus a partial row decodes to 1.
        bus_if.lines = 14'h0007;
        edges(5);
        push("t3_down", 3'd1, 1, 1, 0, 1, 0, 0, 0);
        check();
        edges(1);
        push("t3_pulse_end", 3'd1, 1, 0, 0, 0, 0, 0, 0);
        check();

        // 4: all full, then a short glitch that must not commit.
        bus_if.lines = 14'h3FFF;
        edges(5);
        push("t4_full", 3'd7, 1, 1, 1, 0, 1, 0, 0);
        check();
        edges(2);
        bus_if.lines = 14'h0000;
        for (int i = 0; i < 3; i++) begin
            edges(1);
            push("t4_glitch", 3'd7, 1, 0, 0, 0, 1, 0, 0);
            check();
        end
        bus_if.lines = 14'h3FFF;
        for (int i = 0; i < 6; i++) begin
            edges(1);
            push("t4_recover", 3'd7, 1, 0, 0, 0, 1, 0, 0);
            check();
        end

        // 5: gap at row 1 is a fault; a valid pattern clears it.
        bus_if.lines = 14'h0C03;
        edges(5);
        push("t5_fault", 3'd7, 1, 0, 0, 0, 1, 0, 1);
        check();
        bus_if.lines = 14'h003F;
        edges(4);
        push("t5_fault_held", 3'd7, 1, 0, 0, 0, 1, 0, 1);
        check();
        edges(1);
        push("t5_clear", 3'd3, 1, 1, 0, 1, 0, 0, 0);
        check();

        // 6: reset inside a debounce window clears outputs immediately.
        bus_if.lines = 14'h00FF;
        edges(3);
        rst = 1'b1;
        #1;
        push("t6_async_rst", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        check();
        @(negedge clk);
        rst = 1'b0;
        edges(4);
        push("t6_precommit", 3'd0, 0, 0, 0, 0, 0, 0, 0);
        check();
        edges(1);
        push("t6_commit", 3'd4, 1, 0, 0, 0, 0, 0, 0);
        check();

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
